// File: rtl/cmd_frame_tx.sv
// cmd_frame_tx: serializes one (opcode, key, value) command into a framed
// byte stream: SOF, opcode, key bytes (MSB first), value bytes (MSB first),
// then an XOR checksum over opcode, key and value.
//
// Handshakes: both ports use valid/ready. A transfer happens on a rising
// edge where valid and ready are both high. A source holds valid and its
// payload stable until the transfer. cmd_ready is registered and is high
// only in IDLE. tx_valid stays high from SOF through CSUM, and tx_byte
// holds stable while the sink stalls.
module cmd_frame_tx #(
  parameter int          KEY_BYTES = 2,
  parameter int          VAL_BYTES = 2,
  parameter logic [7:0]  SOF       = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [7:0]             cmd_opcode,
  input  logic [KEY_BYTES*8-1:0] cmd_key,
  input  logic [VAL_BYTES*8-1:0] cmd_value,
  output logic [7:0]             tx_byte,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic [15:0]            frames_sent
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SOF  = 3'd1;
  localparam logic [2:0] ST_OPC  = 3'd2;
  localparam logic [2:0] ST_KEY  = 3'd3;
  localparam logic [2:0] ST_VAL  = 3'd4;
  localparam logic [2:0] ST_CSUM = 3'd5;

  localparam logic [3:0] KEY_LAST = 4'(KEY_BYTES - 1);
  localparam logic [3:0] VAL_LAST = 4'(VAL_BYTES - 1);

  logic [2:0]             state;
  logic [7:0]             opc_q;
  logic [KEY_BYTES*8-1:0] key_q;
  logic [VAL_BYTES*8-1:0] val_q;
  logic [7:0]             csum_q;
  logic [3:0]             idx_q;
  logic [7:0]             key_byte;
  logic [7:0]             val_byte;
  logic                   hs;

  assign hs       = tx_valid && tx_ready;
  assign tx_valid = (state != ST_IDLE);
  assign busy     = (state != ST_IDLE);

  // Select the key and value bytes addressed by the current index.
  always_comb begin
    key_byte = 8'h00;
    val_byte = 8'h00;
    for (int i = 0; i < KEY_BYTES; i++)
      if (idx_q == 4'(i)) key_byte = key_q[i*8 +: 8];
    for (int j = 0; j < VAL_BYTES; j++)
      if (idx_q == 4'(j)) val_byte = val_q[j*8 +: 8];
  end

  // Outgoing byte follows the state; all sources are registers, so it is
  // stable for as long as the state does not advance.
  always_comb begin
    tx_byte = 8'h00;
    case (state)
      ST_SOF:  tx_byte = SOF;
      ST_OPC:  tx_byte = opc_q;
      ST_KEY:  tx_byte = key_byte;
      ST_VAL:  tx_byte = val_byte;
      ST_CSUM: tx_byte = csum_q;
      default: tx_byte = 8'h00;
    endcase
  end

  // Frame FSM: capture the command, then advance one byte per handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cmd_ready   <= 1'b1;
      opc_q       <= 8'h00;
      key_q       <= '0;
      val_q       <= '0;
      csum_q      <= 8'h00;
      idx_q       <= 4'd0;
      frames_sent <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            opc_q     <= cmd_opcode;
            key_q     <= cmd_key;
            val_q     <= cmd_value;
            csum_q    <= 8'h00;
            cmd_ready <= 1'b0;
            state     <= ST_SOF;
          end
        end
        ST_SOF: begin
          if (hs) state <= ST_OPC;
        end
        ST_OPC: begin
          if (hs) begin
            csum_q <= csum_q ^ opc_q;
            idx_q  <= KEY_LAST;
            state  <= ST_KEY;
          end
        end
        ST_KEY: begin
          if (hs) begin
            csum_q <= csum_q ^ key_byte;
            if (idx_q == 4'd0) begin
              idx_q <= VAL_LAST;
              state <= ST_VAL;
            end else begin
              idx_q <= idx_q - 4'd1;
            end
          end
        end
        ST_VAL: begin
          if (hs) begin
            csum_q <= csum_q ^ val_byte;
            if (idx_q == 4'd0) state <= ST_CSUM;
            else               idx_q <= idx_q - 4'd1;
          end
        end
        ST_CSUM: begin
          if (hs) begin
            frames_sent <= frames_sent + 16'd1;
            cmd_ready   <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Directed bench for cmd_frame_tx: a 2/2-byte instance (a) and a 1/1-byte
// instance (b) share clock, reset, opcode and tx_ready.
module tb_cmd_frame_tx;

  logic        clk;
  logic        rst_n;
  logic        tx_ready;
  logic [7:0]  cmd_opcode;

  logic        a_cmd_valid, a_cmd_ready, a_tx_valid, a_busy;
  logic [15:0] a_cmd_key, a_cmd_value, a_frames_sent;
  logic [7:0]  a_tx_byte;

  logic        b_cmd_valid, b_cmd_ready, b_tx_valid, b_busy;
  logic [7:0]  b_cmd_key, b_cmd_value, b_tx_byte;
  logic [15:0] b_frames_sent;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  cmd_frame_tx #(.KEY_BYTES(2), .VAL_BYTES(2), .SOF(8'hA5)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_key(a_cmd_key), .cmd_value(a_cmd_value),
    .tx_byte(a_tx_byte), .tx_valid(a_tx_valid), .tx_ready(tx_ready),
    .busy(a_busy), .frames_sent(a_frames_sent)
  );

  cmd_frame_tx #(.KEY_BYTES(1), .VAL_BYTES(1), .SOF(8'hA5)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_key(b_cmd_key), .cmd_value(b_cmd_value),
    .tx_byte(b_tx_byte), .tx_valid(b_tx_valid), .tx_ready(tx_ready),
    .busy(b_busy), .frames_sent(b_frames_sent)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a command to instance a at a falling edge; acceptance is at the
  // following rising edge. Returns at the next falling edge.
  task automatic accept_a(input logic [7:0] o, input logic [15:0] k, input logic [15:0] v);
    check("a_accept_ready", {15'd0, a_cmd_ready}, 16'd1);
    a_cmd_valid = 1'b1; cmd_opcode = o; a_cmd_key = k; a_cmd_value = v;
    @(posedge clk);
    @(negedge clk);
    a_cmd_valid = 1'b0;
  endtask

  task automatic accept_b(input logic [7:0] o, input logic [7:0] k, input logic [7:0] v);
    check("b_accept_ready", {15'd0, b_cmd_ready}, 16'd1);
    b_cmd_valid = 1'b1; cmd_opcode = o; b_cmd_key = k; b_cmd_value = v;
    @(posedge clk);
    @(negedge clk);
    b_cmd_valid = 1'b0;
  endtask

  // Consume exp_q from instance sel (0=a, 1=b), optionally stalling with the
  // repeating tx_ready pattern 1,0,0,1. Every cycle checks tx_valid, tx_byte
  // and that cmd_ready is low; afterwards checks the return to idle.
  task automatic drain(input bit sel, input bit stall, input int exp_len,
                       input logic [15:0] exp_frames, input string tag);
    int cyc = 0;
    logic v, r;
    logic [7:0] b;
    while (exp_q.size() > 0 && cyc < 64) begin
      tx_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      v = sel ? b_tx_valid : a_tx_valid;
      b = sel ? b_tx_byte  : a_tx_byte;
      r = sel ? b_cmd_ready : a_cmd_ready;
      check({tag, "_valid"}, {15'd0, v}, 16'd1);
      check({tag, "_byte"}, {8'd0, b}, {8'd0, exp_q[0]});
      check({tag, "_busy_rdy"}, {15'd0, r}, 16'd0);
      if (tx_ready) void'(exp_q.pop_front());
      cyc++;
      @(negedge clk);
    end
    check({tag, "_drained"}, 16'(exp_q.size()), 16'd0);
    if (!stall) check({tag, "_len"}, 16'(cyc), 16'(exp_len));
    check({tag, "_end_valid"}, {15'd0, sel ? b_tx_valid : a_tx_valid}, 16'd0);
    check({tag, "_end_ready"}, {15'd0, sel ? b_cmd_ready : a_cmd_ready}, 16'd1);
    check({tag, "_frames"}, sel ? b_frames_sent : a_frames_sent, exp_frames);
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; tx_ready = 1'b0; cmd_opcode = 8'h00;
    a_cmd_valid = 1'b0; a_cmd_key = 16'h0; a_cmd_value = 16'h0;
    b_cmd_valid = 1'b0; b_cmd_key = 8'h0; b_cmd_value = 8'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state.
    check("rst_ready",  {15'd0, a_cmd_ready}, 16'd1);
    check("rst_valid",  {15'd0, a_tx_valid},  16'd0);
    check("rst_byte",   {8'd0, a_tx_byte},    16'h0000);
    check("rst_busy",   {15'd0, a_busy},      16'd0);
    check("rst_frames", a_frames_sent,        16'd0);

    // tx_ready high while idle has no effect.
    tx_ready = 1'b1;
    @(negedge clk);
    check("idle_ready_valid", {15'd0, a_tx_valid}, 16'd0);
    check("idle_ready_busy",  {15'd0, a_busy},     16'd0);

    // Frame 1, no stalls: A5 01 12 34 AB CD 41.
    accept_a(8'h01, 16'h1234, 16'hABCD);
    exp_q = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    drain(1'b0, 1'b0, 7, 16'd1, "f1");

    // Same frame with stalls.
    accept_a(8'h01, 16'h1234, 16'hABCD);
    exp_q = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    drain(1'b0, 1'b1, 7, 16'd2, "f1stall");

    // Second command held pending during a frame.
    accept_a(8'h01, 16'h1234, 16'hABCD);
    a_cmd_valid = 1'b1; cmd_opcode = 8'h02; a_cmd_key = 16'h0000; a_cmd_value = 16'h0000;
    exp_q = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    drain(1'b0, 1'b0, 7, 16'd3, "f1held");
    @(posedge clk);
    @(negedge clk);
    a_cmd_valid = 1'b0;
    exp_q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
    drain(1'b0, 1'b0, 7, 16'd4, "f2");

    // Reset asserted in the KEY state.
    accept_a(8'h01, 16'h1234, 16'hABCD);
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_busy", {15'd0, a_busy}, 16'd1);
    check("mid_byte", {8'd0, a_tx_byte}, 16'h0034);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid",  {15'd0, a_tx_valid},  16'd0);
    check("arst_ready",  {15'd0, a_cmd_ready}, 16'd1);
    check("arst_busy",   {15'd0, a_busy},      16'd0);
    check("arst_frames", a_frames_sent,        16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", {15'd0, a_tx_valid}, 16'd0);
    accept_a(8'h01, 16'h1234, 16'hABCD);
    exp_q = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    drain(1'b0, 1'b0, 7, 16'd1, "fresh");

    // Counter wrap: preload the counter to all ones.
    dut_a.frames_sent = 16'hFFFF;
    @(negedge clk);
    accept_a(8'h01, 16'h1234, 16'hABCD);
    exp_q = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    drain(1'b0, 1'b0, 7, 16'd0, "wrap");

    // One-byte key and value: A5 FF FF 00 00.
    accept_b(8'hFF, 8'hFF, 8'h00);
    exp_q = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h00};
    drain(1'b1, 1'b0, 5, 16'd1, "b1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
